// File: rtl/run_controller.sv
// Run/stop sequencer for the single-cycle core: produces the per-cycle commit
// enable and handles run, stop, step, run-N, PC breakpoints and syscall halt.
module run_controller #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [2:0]       state,
  output logic [2:0]       stop_cause,
  output logic             done,
  output logic [31:0]      instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_COUNT  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RUN_N = 2'd3;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_STOP  = 3'd1;
  localparam logic [2:0] C_STEP  = 3'd2;
  localparam logic [2:0] C_COUNT = 3'd3;
  localparam logic [2:0] C_BP    = 3'd4;
  localparam logic [2:0] C_HALT  = 3'd5;

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             bp_skip_q, bp_skip_d;
  logic             halt_pend_q, halt_pend_d;
  logic             done_q, done_d;
  logic             stop_evt;
  logic [31:0]      cnt_q;
  logic             running, bp_hit, accept;

  assign running    = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_COUNT);
  assign bp_hit     = bp_en && (pc == bp_addr) && !bp_skip_q;
  assign cpu_ce     = running && !bp_hit && !halt_req && !reset;
  assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_COUNT);
  assign accept     = cmd_valid && cmd_ready;
  assign state      = state_q;
  assign stop_cause = cause_q;
  assign done       = done_q;
  assign instr_cnt  = cnt_q;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    rem_d       = rem_q;
    bp_skip_d   = bp_skip_q && !cpu_ce;
    halt_pend_d = halt_pend_q;
    stop_evt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt_req) halt_pend_d = 1'b1;
        // A halt seen while idle is honoured by the next run-type command.
        if (accept && cmd_op != OP_STOP) begin
          if (halt_pend_q || halt_req) begin
            state_d  = S_HALTED;
            cause_d  = C_HALT;
            stop_evt = 1'b1;
          end else if (cmd_op == OP_RUN) begin
            state_d = S_RUN;
          end else if (cmd_op == OP_STEP) begin
            state_d = S_STEP;
          end else if (cmd_arg != '0) begin
            rem_d   = cmd_arg;
            state_d = S_COUNT;
          end else begin
            cause_d  = C_COUNT;
            stop_evt = 1'b1;
          end
        end
      end
      S_RUN, S_STEP, S_COUNT: begin
        if (cpu_ce && state_q == S_COUNT) rem_d = rem_q - 1'b1;
        if (halt_req) begin
          state_d  = S_HALTED;
          cause_d  = C_HALT;
          stop_evt = 1'b1;
        end else if (bp_hit) begin
          state_d   = S_IDLE;
          cause_d   = C_BP;
          bp_skip_d = 1'b1;
          stop_evt  = 1'b1;
        end else if (accept && cmd_op == OP_STOP) begin
          state_d  = S_IDLE;
          cause_d  = C_STOP;
          stop_evt = 1'b1;
        end else if (state_q == S_STEP) begin
          state_d  = S_IDLE;
          cause_d  = C_STEP;
          stop_evt = 1'b1;
        end else if (state_q == S_COUNT && rem_q == 1) begin
          state_d  = S_IDLE;
          cause_d  = C_COUNT;
          stop_evt = 1'b1;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
    // Back-to-back stop events collapse so the pulse is never two cycles wide.
    done_d = stop_evt && !done_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cause_q     <= C_NONE;
      rem_q       <= '0;
      bp_skip_q   <= 1'b0;
      halt_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      rem_q       <= rem_d;
      bp_skip_q   <= bp_skip_d;
      halt_pend_q <= halt_pend_d;
      done_q      <= done_d;
      if (cpu_ce) cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequences execution of the single-cycle CPU core by generating the per-cycle commit enable `cpu_ce`.
- When `cpu_ce` is low, the core's PC, register file, data memory and statistics writes hold their values.
- Accepts debug commands: run, stop, single-step, run-N.
- Stops the core on a PC breakpoint, and freezes it permanently on the syscall halt request.
- Sits between the board debug interface and the CPU top, replacing direct clock gating.

Parameters:
- CNT_W, 16, width of the run-N count argument and of the remaining-count register.
- PC_W, 32, width of the PC and breakpoint address.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a cycle when cmd_valid && cmd_ready.
- cmd_op  in  2  command code: 0 RUN, 1 STOP, 2 STEP, 3 RUN_N.
- cmd_arg  in  CNT_W  instruction count for RUN_N; ignored for other ops.
- pc  in  PC_W  PC of the instruction the core will commit this cycle.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint address.
- halt_req  in  1  syscall halt from the syscall decoder; level signal.
- cpu_ce  out  1  commit enable to the core (combinational).
- state  out  3  current state: 0 IDLE, 1 RUN, 2 STEP, 3 COUNT, 4 HALTED.
- stop_cause  out  3  reason for the last stop: 0 NONE, 1 STOP, 2 STEP, 3 COUNT, 4 BP, 5 HALT.
- done  out  1  one-cycle pulse when the controller enters IDLE or HALTED from a running state.
- instr_cnt  out  32  count of committed instructions.

Behaviour:
- Reset (synchronous):
  - state=IDLE, stop_cause=NONE, done=0, instr_cnt=0, remaining=0, bp_skip=0.
  - cpu_ce=0 during the reset cycle.
- cmd_ready = (state==IDLE || state==RUN || state==COUNT).
  - It is 0 in STEP and HALTED.
- Commands accepted in IDLE:
  - RUN: go to RUN.
  - STEP: go to STEP.
  - RUN_N with cmd_arg≠0: remaining←cmd_arg, go to COUNT.
  - RUN_N with cmd_arg=0: stay IDLE, stop_cause←COUNT, done pulses the next cycle.
  - STOP: no effect.
- Commands accepted in RUN/COUNT:
  - STOP: go to IDLE, stop_cause←STOP.
  - Any other op is accepted and discarded.
- Latency:
  - A command accepted at cycle t changes state at t+1.
  - The first cpu_ce=1 occurs at t+1.
  - After STOP is accepted at t, cpu_ce is 0 from t+1 onward. cpu_ce may be 1 in cycle t itself, so the commit in t still happens.
- bp_hit = bp_en && (pc==bp_addr) && !bp_skip.
- cpu_ce = (state∈{RUN,STEP,COUNT}) && !bp_hit && !halt_req.
- Breakpoint: in a running state with bp_hit:
  - the instruction at bp_addr does NOT commit;
  - go to IDLE, stop_cause←BP;
  - bp_skip←1.
- bp_skip:
  - Cleared on the first cycle in which cpu_ce=1.
  - Therefore resuming from a breakpoint executes the breakpoint instruction once instead of re-trapping.
- STEP: exactly one cycle with cpu_ce=1, then IDLE, stop_cause←STEP.
  - A breakpoint or halt takes precedence as specified below.
- COUNT:
  - Each cpu_ce=1 cycle decrements remaining.
  - When remaining==1 && cpu_ce: go to IDLE, stop_cause←COUNT.
  - Exactly cmd_arg instructions commit.
- Halt: halt_req=1 while in any running state forces state←HALTED, stop_cause←HALT.
  - Only reset leaves HALTED.
  - halt_req while IDLE is latched: the next run command goes directly to HALTED with no commit.
- Priority when events coincide in one cycle: halt_req > bp_hit > STOP command > STEP/COUNT completion.
  - stop_cause reflects the winner.
- done:
  - Registered: high in the cycle after any transition into IDLE or HALTED, including RUN_N 0.
  - Never high for two consecutive cycles.
- instr_cnt:
  - Increments on every cpu_ce=1 cycle.
  - Wraps from 0xFFFFFFFF to 0.
  - It is not cleared by commands.
- remaining: keeps its value in IDLE and is reloaded by every accepted RUN_N.
- Reset mid-run: takes effect at the next edge; in-flight count and cause are lost.

Test Plan:
- Reset, then RUN_N arg=5 with bp_en=0 → cpu_ce high for exactly 5 consecutive cycles starting 1 cycle after accept; instr_cnt=5; stop_cause=3; single done pulse.
- RUN, then STOP accepted 10 cycles later → instr_cnt=10 (commit in the STOP accept cycle counted); stop_cause=1; cpu_ce=0 afterwards.
- bp_en=1, bp_addr=0x20, pc steps 0x0,0x4,… under RUN → instr_cnt=8; cpu_ce=0 at pc=0x20; stop_cause=4. Then STEP → 0x20 commits, instr_cnt=9, stop_cause=2.
- halt_req rises during COUNT remaining=3, in the same cycle as bp_hit and a STOP command → state=4, stop_cause=5, cpu_ce=0. Subsequent commands see cmd_ready=0; only reset restores IDLE.
- RUN_N arg=0 → no cpu_ce; done pulses once; stop_cause=3. STEP while in STEP → cmd_ready=0 and the command is held.
- Preload instr_cnt near wrap: RUN_N arg=2 from 0xFFFFFFFF → instr_cnt=1 afterwards. Reset asserted mid-COUNT → next cycle state=0, instr_cnt=0, cpu_ce=0.
